mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port word memory, with fetch starvation guard.
// Define MEM_ARBITER_RMW_EN to turn sub-word stores into a read-modify-write of the whole word.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [31:0]           dm_wdata,
  input  logic [1:0]            dm_swhb,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [31:0]           dm_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [31:0]           mem_rdata,
  output logic                  stall_if,
  output logic                  stall_mem
);

`ifdef MEM_ARBITER_RMW_EN
  localparam bit RMW_EN = 1'b1;
`else
  localparam bit RMW_EN = 1'b0;
`endif

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic {ARB = 1'b0, RMW_MERGE = 1'b1} state_e;

  function automatic logic [3:0] lane_strb(input logic [1:0] swhb, input logic [1:0] lsb);
    case (swhb)
      2'b01:   return 4'b0001 << lsb;
      2'b10:   return 4'b0011 << {lsb[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] swhb, input logic [1:0] lsb,
                                            input logic [31:0] wdata);
    case (swhb)
      2'b01:   return {24'b0, wdata[7:0]} << {lsb, 3'b000};
      2'b10:   return {16'b0, wdata[15:0]} << {lsb[1], 4'b0000};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        starve_q, starve_d;
  logic                    run_q;
  logic                    if_rvalid_q, if_rvalid_d;
  logic                    dm_rvalid_q, dm_rvalid_d;
  logic [ADDR_WIDTH-3:0]   rmw_addr_q, rmw_addr_d;
  logic [31:0]             rmw_data_q, rmw_data_d;
  logic [3:0]              rmw_strb_q, rmw_strb_d;
  logic                    dm_sub, fetch_first;
  logic                    unused_addr;

  assign unused_addr = ^if_addr[1:0];

  always_comb begin
    state_d     = state_q;
    rmw_addr_d  = rmw_addr_q;
    rmw_data_d  = rmw_data_q;
    rmw_strb_d  = rmw_strb_q;
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    dm_sub      = dm_we && (dm_swhb == 2'b01 || dm_swhb == 2'b10);
    fetch_first = if_req && (starve_q == STARVE_LIM);
    // run_q holds grants off until the first clock edge after reset release
    if (run_q) begin
      case (state_q)
        ARB: begin
          if (dm_req && !fetch_first) begin
            mem_en   = 1'b1;
            mem_addr = dm_addr[ADDR_WIDTH-1:2];
            if (RMW_EN && dm_sub) begin
              rmw_addr_d = dm_addr[ADDR_WIDTH-1:2];
              rmw_data_d = lane_data(dm_swhb, dm_addr[1:0], dm_wdata);
              rmw_strb_d = lane_strb(dm_swhb, dm_addr[1:0]);
              state_d    = RMW_MERGE;
            end else begin
              dm_gnt = 1'b1;
              mem_we = dm_we;
              if (dm_we) begin
                mem_wdata = lane_data(dm_swhb, dm_addr[1:0], dm_wdata);
                mem_wstrb = lane_strb(dm_swhb, dm_addr[1:0]);
              end
            end
          end else if (if_req) begin
            if_gnt   = 1'b1;
            mem_en   = 1'b1;
            mem_addr = if_addr[ADDR_WIDTH-1:2];
          end
        end
        RMW_MERGE: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = rmw_addr_q;
          mem_wdata = merge_word(mem_rdata, rmw_data_q, rmw_strb_q);
          mem_wstrb = 4'b1111;
          dm_gnt    = 1'b1;
          state_d   = ARB;
        end
        default: state_d = ARB;
      endcase
    end
    stall_if  = run_q && if_req && !if_gnt;
    stall_mem = run_q && dm_req && !dm_gnt;
    if (if_gnt)                               starve_d = '0;
    else if (stall_if && starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
    else                                      starve_d = starve_q;
    if_rvalid_d = if_gnt;
    dm_rvalid_d = dm_gnt && !mem_we;
    if_rdata    = if_rvalid_q ? mem_rdata : 32'h0;
    dm_rdata    = dm_rvalid_q ? mem_rdata : 32'h0;
    if_rvalid   = if_rvalid_q;
    dm_rvalid   = dm_rvalid_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB;
      starve_q    <= '0;
      run_q       <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      run_q       <= 1'b1;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
    end
  end

  // Merge operands are only consumed in RMW_MERGE, so they carry no reset
  always_ff @(posedge clk) begin
    rmw_addr_q <= rmw_addr_d;
    rmw_data_q <= rmw_data_d;
    rmw_strb_q <= rmw_strb_d;
  end

endmodule
